// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: operand forwarding, condition evaluation, next-PC select, 2-bit BHT.
// Optional performance counters are built only when BRANCH_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        fwd_sel_a,
  input  logic [1:0]        fwd_sel_b,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] result_w,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] alu_out_e,
  input  logic              j,
  input  logic              jal,
  input  logic              jr,
  input  logic [2:0]        branch_d,
  input  logic              stall_d,
  input  logic [PC_W-1:0]   pc_f,
  input  logic [PC_W-1:0]   pc_d,
  input  logic              pred_taken_d,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  output logic              taken,
  output logic [1:0]        pcsrc,
  output logic              pred_taken_f,
  output logic              mispredict
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
`endif
);
  localparam int DEPTH = 2**BHT_IDX_W;

  logic [DEPTH-1:0][1:0]  bht;
  logic [BHT_IDX_W-1:0]   idx_f, idx_d;
  logic [1:0]             ctr_d;
  logic                   eq, a_neg, a_zero, cond, jump, train;

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel, input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] m,
                                                input logic [DATA_W-1:0] e);
    case (sel)
      2'b00:   return rf;
      2'b01:   return w;
      2'b10:   return m;
      default: return e;
    endcase
  endfunction

  assign cmp_a = fwd_mux(fwd_sel_a, qa, result_w, alu_out_m, alu_out_e);
  assign cmp_b = fwd_mux(fwd_sel_b, qb, result_w, alu_out_m, alu_out_e);

  assign eq     = (cmp_a == cmp_b);
  assign a_neg  = cmp_a[DATA_W-1];
  assign a_zero = (cmp_a == '0);

  always_comb begin
    cond = 1'b0;
    case (branch_d)
      3'd1:    cond = eq;
      3'd2:    cond = !eq;
      3'd3:    cond = a_neg | a_zero;
      3'd4:    cond = !a_neg & !a_zero;
      3'd5:    cond = !a_neg;
      3'd6:    cond = a_zero;
      3'd7:    cond = a_neg;
      default: cond = 1'b0;
    endcase
  end

  assign taken      = cond;
  assign jump       = j | jal | jr;
  assign pcsrc      = {taken & ~jump, jump};
  assign train      = (branch_d != 3'd0) & !stall_d;
  assign mispredict = train & (taken != pred_taken_d);

  // Word-aligned PCs: bits [1:0] are dropped, higher bits alias.
  assign idx_f        = pc_f[BHT_IDX_W+1:2];
  assign idx_d        = pc_d[BHT_IDX_W+1:2];
  assign ctr_d        = bht[idx_d];
  assign pred_taken_f = bht[idx_f][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
    end else if (train) begin
      if (taken && ctr_d != 2'b11)       bht[idx_d] <= ctr_d + 2'd1;
      else if (!taken && ctr_d != 2'b00) bht[idx_d] <= ctr_d - 2'd1;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (train && perf_branches != '1)         perf_branches    <= perf_branches + 32'd1;
      if (mispredict && perf_mispredicts != '1) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

  logic unused_pc;
  assign unused_pc = ^{pc_f[PC_W-1:BHT_IDX_W+2], pc_f[1:0], pc_d[PC_W-1:BHT_IDX_W+2], pc_d[1:0]};
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against an arithmetic reference model.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] qa, qb, result_w, alu_out_m, alu_out_e;
  logic        j, jal, jr;
  logic [2:0]  branch_d;
  logic        stall_d;
  logic [31:0] pc_f, pc_d;
  logic        pred_taken_d;
  logic [31:0] cmp_a, cmp_b;
  logic        taken;
  logic [1:0]  pcsrc;
  logic        pred_taken_f, mispredict;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .qa(qa), .qb(qb), .result_w(result_w), .alu_out_m(alu_out_m), .alu_out_e(alu_out_e),
    .j(j), .jal(jal), .jr(jr), .branch_d(branch_d), .stall_d(stall_d),
    .pc_f(pc_f), .pc_d(pc_d), .pred_taken_d(pred_taken_d),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .taken(taken), .pcsrc(pcsrc),
    .pred_taken_f(pred_taken_f), .mispredict(mispredict)
`ifdef BRANCH_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bht_m[16];
  longint pb_m = 0, pm_m = 0;

  function automatic logic [31:0] ref_sel(input logic [1:0] s, input logic [31:0] rf);
    case (s)
      2'd0: return rf;
      2'd1: return result_w;
      2'd2: return alu_out_m;
      default: return alu_out_e;
    endcase
  endfunction

  function automatic logic ref_taken();
    int signed a, b;
    a = $signed(ref_sel(fwd_sel_a, qa));
    b = $signed(ref_sel(fwd_sel_b, qb));
    case (branch_d)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return a <= 0;
      3'd4: return a > 0;
      3'd5: return a >= 0;
      3'd6: return a == 0;
      3'd7: return a < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] ref_pcsrc();
    if (j || jal || jr) return 2'b01;
    if (ref_taken()) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic ref_mispredict();
    return (branch_d != 0) && !stall_d && (ref_taken() != pred_taken_d);
  endfunction

  function automatic logic ref_pred(input logic [31:0] pc);
    return bht_m[(pc / 4) % 16] >= 2;
  endfunction

  // Advance one clock edge and apply the model's state update for the current inputs.
  task automatic step();
    logic tk;
    int k;
    tk = ref_taken();
    if (rst) begin
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
      pb_m = 0; pm_m = 0;
    end else if (branch_d != 0 && !stall_d) begin
      k = (pc_d / 4) % 16;
      if (tk) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
      else    bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      if (pb_m != 64'hFFFF_FFFF) pb_m++;
      if (tk != pred_taken_d && pm_m != 64'hFFFF_FFFF) pm_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; fwd_sel_a = 0; fwd_sel_b = 0; qa = 0; qb = 0; result_w = 0; alu_out_m = 0;
    alu_out_e = 0; j = 0; jal = 0; jr = 0; branch_d = 0; stall_d = 0; pc_f = 0; pc_d = 0;
    pred_taken_d = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pc_f = i * 4; #1;
      checks++;
      if (pred_taken_f !== 1'b0) begin
        errors++; $display("FAIL reset_pred idx=%0d got=%b exp=0", i, pred_taken_f);
      end
    end
`ifdef BRANCH_PERF_CNT_EN
    checks++;
    if (perf_branches !== 0 || perf_mispredicts !== 0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts);
    end
`endif
  endtask

  task automatic test_forwarding();
    idle(); qa = 5; alu_out_e = 7; fwd_sel_a = 2'b11; fwd_sel_b = 2'b00; qb = 7; branch_d = 1; #1;
    checks++;
    if (cmp_a !== 32'd7 || taken !== 1'b1 || pcsrc !== 2'b10) begin
      errors++; $display("FAIL fwd cmp_a=%0d taken=%b pcsrc=%b exp=7/1/10", cmp_a, taken, pcsrc);
    end
    for (int s = 0; s < 4; s++) begin
      qa = 11; result_w = 22; alu_out_m = 33; alu_out_e = 44; qb = 55;
      fwd_sel_a = s[1:0]; fwd_sel_b = 2'(3 - s); #1;
      checks++;
      if (cmp_a !== ref_sel(fwd_sel_a, qa) || cmp_b !== ref_sel(fwd_sel_b, qb)) begin
        errors++; $display("FAIL fwd_mux sel=%0d got=%0d/%0d exp=%0d/%0d", s, cmp_a, cmp_b,
                           ref_sel(fwd_sel_a, qa), ref_sel(fwd_sel_b, qb));
      end
    end
    idle();
  endtask

  task automatic test_signed_zero();
    logic [2:0] bt[3] = '{3'd7, 3'd4, 3'd5};
    logic       ex[3] = '{1'b1, 1'b0, 1'b0};
    idle(); qa = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      branch_d = bt[i]; #1;
      checks++;
      if (taken !== ex[i]) begin
        errors++; $display("FAIL signed_zero bt=%0d got=%b exp=%b", bt[i], taken, ex[i]);
      end
    end
    qa = 0; branch_d = 6; #1;
    checks++;
    if (taken !== 1'b1) begin errors++; $display("FAIL beqz_zero got=%b exp=1", taken); end
    idle();
  endtask

  task automatic test_jump_priority();
    idle(); jr = 1; branch_d = 1; qa = 9; qb = 9; stall_d = 1; #1;
    checks++;
    if (pcsrc !== 2'b01) begin errors++; $display("FAIL jump_prio got=%b exp=01", pcsrc); end
    idle();
  endtask

  task automatic test_bht_saturation();
    logic [1:0] exp_p[4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    do_reset();
    pc_d = 32'h40; pc_f = 32'h40; branch_d = 1; qa = 3; qb = 3; pred_taken_d = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pred_taken_f !== exp_p[i][1]) begin
        errors++; $display("FAIL bht_inc step=%0d got=%b exp=%b", i, pred_taken_f, exp_p[i][1]);
      end
      step();
    end
    checks++;
    if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL bht_sat got=%b exp=1", pred_taken_f); end
    branch_d = 2; step();
    checks++;
    if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL bht_dec got=%b exp=1", pred_taken_f); end
    step(); step();
    checks++;
    if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL bht_dec2 got=%b exp=0", pred_taken_f); end
    idle();
  endtask

  task automatic test_stall_mispredict();
    do_reset();
    pc_d = 32'h44; pc_f = 32'h44; branch_d = 1; qa = 1; qb = 1; pred_taken_d = 0; stall_d = 1;
    qa = 2; qb = 2; #1;
    checks++;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL stall_mp got=%b exp=0", mispredict); end
    step();
    checks++;
    if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL stall_bht got=%b exp=0", pred_taken_f); end
    stall_d = 0; #1;
    checks++;
    if (mispredict !== 1'b1) begin errors++; $display("FAIL release_mp got=%b exp=1", mispredict); end
    step();
    checks++;
    if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL release_bht got=%b exp=1", pred_taken_f); end
`ifdef BRANCH_PERF_CNT_EN
    checks++;
    if (perf_branches !== 1 || perf_mispredicts !== 1) begin
      errors++; $display("FAIL stall_cnt got=%0d/%0d exp=1/1", perf_branches, perf_mispredicts);
    end
`endif
    idle();
  endtask

  task automatic test_reset_mid_training();
    idle();
    pc_d = 32'h48; pc_f = 32'h48; branch_d = 1; qa = 4; qb = 4;
    step(); step();
    rst = 1; step(); rst = 0; branch_d = 0; #1;
    checks++;
    if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL rst_mid_pred got=%b exp=0", pred_taken_f); end
`ifdef BRANCH_PERF_CNT_EN
    checks++;
    if (perf_branches !== 0 || perf_mispredicts !== 0) begin
      errors++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts);
    end
`endif
    branch_d = 1; step();
    checks++;
    if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL rst_mid_weak got=%b exp=1", pred_taken_f); end
    idle();
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'd5;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom);
      qa = rnd_data(); qb = rnd_data(); result_w = rnd_data(); alu_out_m = rnd_data();
      alu_out_e = rnd_data();
      j = ($urandom_range(0, 9) == 0); jal = ($urandom_range(0, 9) == 0); jr = ($urandom_range(0, 9) == 0);
      branch_d = 3'($urandom); stall_d = ($urandom_range(0, 4) == 0);
      pc_f = $urandom_range(0, 31) * 4 + 32'(($urandom % 2) << 20);
      pc_d = $urandom_range(0, 31) * 4 + 32'(($urandom % 2) << 24);
      pred_taken_d = 1'($urandom);
      #1;
      checks++;
      if (cmp_a !== ref_sel(fwd_sel_a, qa) || cmp_b !== ref_sel(fwd_sel_b, qb) ||
          taken !== ref_taken() || pcsrc !== ref_pcsrc() || mispredict !== ref_mispredict() ||
          pred_taken_f !== ref_pred(pc_f)) begin
        errors++;
        $display("FAIL rand n=%0d a=%h b=%h tk=%b pc=%b mp=%b pf=%b exp a=%h b=%h tk=%b pc=%b mp=%b pf=%b",
                 n, cmp_a, cmp_b, taken, pcsrc, mispredict, pred_taken_f, ref_sel(fwd_sel_a, qa),
                 ref_sel(fwd_sel_b, qb), ref_taken(), ref_pcsrc(), ref_mispredict(), ref_pred(pc_f));
      end
      step();
`ifdef BRANCH_PERF_CNT_EN
      checks++;
      if (perf_branches !== 32'(pb_m) || perf_mispredicts !== 32'(pm_m)) begin
        errors++; $display("FAIL rand_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, perf_branches,
                           perf_mispredicts, pb_m, pm_m);
      end
`endif
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_signed_zero();
    test_jump_priority();
    test_bht_saturation();
    test_stall_mispredict();
    test_reset_mid_training();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
